// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cdb_arbiter
// Purpose  : Per-source result FIFOs with round-robin grant onto the registered
//            Common Data Bus. Optional counters enabled by CDB_ARB_STATS_EN.
// Revision : 1.0
// ============================================================================
module cdb_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int DEPTH   = 2,
  parameter int TAG_W   = 5,
  parameter int VAL_W   = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_SRC-1:0]       in_src_valid,
  input  logic [NUM_SRC*TAG_W-1:0] in_src_tag,
  input  logic [NUM_SRC*VAL_W-1:0] in_src_val,
  input  logic [NUM_SRC*4-1:0]     in_src_icc,
  input  logic [NUM_SRC-1:0]       in_src_icc_wr,
  output logic [NUM_SRC-1:0]       out_src_ready,
  output logic                     out_CDB_broadcast,
  output logic [TAG_W-1:0]         out_CDB_tag,
  output logic [VAL_W-1:0]         out_CDB_val,
  output logic [3:0]               out_ICC_flags,
  output logic                     out_ICC_wr,
  output logic [2:0]               out_CDB_src
`ifdef CDB_ARB_STATS_EN
  ,
  output logic [15:0]              out_conflict_cnt,
  output logic [7:0]               out_drop_cnt
`endif
);

  localparam int c_SRC_W = $clog2(NUM_SRC);
  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = $clog2(DEPTH + 1);
  localparam int c_ENT_W = 1 + 4 + VAL_W + TAG_W;
  localparam logic [TAG_W-1:0] c_INVALID_TAG = {TAG_W{1'b1}};

  logic [NUM_SRC-1:0]         w_nonempty;
  logic [NUM_SRC-1:0]         w_accept;
  logic [NUM_SRC-1:0]         w_push;
  logic [NUM_SRC-1:0]         w_pop;
  logic [NUM_SRC*c_ENT_W-1:0] w_head_flat;
  logic                       w_grant_vld;
  logic [c_SRC_W-1:0]         w_grant_idx;
  logic [c_SRC_W:0]           w_cand;
  logic [c_SRC_W-1:0]         w_cand_idx;
  logic [c_ENT_W-1:0]         w_sel;
  logic [c_SRC_W-1:0]         r_ptr;

  // Entry layout, LSB first: tag, value, icc flags, icc write enable.
  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    logic [c_ENT_W-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [TAG_W-1:0]   w_tag;

    assign w_tag            = in_src_tag[k*TAG_W +: TAG_W];
    assign out_src_ready[k] = (r_count != c_CNT_W'(DEPTH));
    assign w_accept[k]      = in_src_valid[k] & out_src_ready[k];
    assign w_push[k]        = w_accept[k] & (w_tag != c_INVALID_TAG);
    assign w_nonempty[k]    = (r_count != '0);
    assign w_pop[k]         = w_grant_vld & (w_grant_idx == c_SRC_W'(k));
    assign w_head_flat[k*c_ENT_W +: c_ENT_W] = r_mem[r_rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push[k]) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop[k])  r_rd_ptr <= r_rd_ptr + 1'b1;
        case ({w_push[k], w_pop[k]})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (w_push[k])
        r_mem[r_wr_ptr] <= {in_src_icc_wr[k], in_src_icc[k*4 +: 4],
                            in_src_val[k*VAL_W +: VAL_W], w_tag};
    end
  end

  // Round-robin search starting at r_ptr, wrapping past NUM_SRC-1.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    w_cand      = '0;
    w_cand_idx  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_cand = {1'b0, r_ptr} + (c_SRC_W+1)'(i);
      if (w_cand >= (c_SRC_W+1)'(NUM_SRC))
        w_cand = w_cand - (c_SRC_W+1)'(NUM_SRC);
      w_cand_idx = w_cand[c_SRC_W-1:0];
      if (!w_grant_vld && w_nonempty[w_cand_idx]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = w_cand_idx;
      end
    end
  end

  always_comb begin
    w_sel = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (w_grant_idx == c_SRC_W'(k))
        w_sel = w_head_flat[k*c_ENT_W +: c_ENT_W];
    end
  end

  // Data outputs hold when idle; only the strobes fall back to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr             <= '0;
      out_CDB_broadcast <= 1'b0;
      out_CDB_tag       <= c_INVALID_TAG;
      out_CDB_val       <= '0;
      out_ICC_flags     <= '0;
      out_ICC_wr        <= 1'b0;
      out_CDB_src       <= '0;
    end else begin
      out_CDB_broadcast <= w_grant_vld;
      if (w_grant_vld) begin
        r_ptr         <= (w_grant_idx == c_SRC_W'(NUM_SRC-1)) ? '0 : w_grant_idx + 1'b1;
        out_CDB_tag   <= w_sel[TAG_W-1:0];
        out_CDB_val   <= w_sel[TAG_W +: VAL_W];
        out_ICC_flags <= w_sel[TAG_W+VAL_W +: 4];
        out_ICC_wr    <= w_sel[c_ENT_W-1];
        out_CDB_src   <= 3'(w_grant_idx);
      end else begin
        out_ICC_wr    <= 1'b0;
      end
    end
  end

`ifdef CDB_ARB_STATS_EN
  logic [3:0] w_ne_num;
  logic [3:0] w_drop_num;
  logic [8:0] w_drop_sum;

  always_comb begin
    w_ne_num   = '0;
    w_drop_num = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      w_ne_num = w_ne_num + 4'(w_nonempty[k]);
      if (w_accept[k] && (in_src_tag[k*TAG_W +: TAG_W] == c_INVALID_TAG))
        w_drop_num = w_drop_num + 4'd1;
    end
  end

  assign w_drop_sum = {1'b0, out_drop_cnt} + 9'(w_drop_num);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_conflict_cnt <= '0;
      out_drop_cnt     <= '0;
    end else begin
      if ((w_ne_num >= 4'd2) && (out_conflict_cnt != 16'hFFFF))
        out_conflict_cnt <= out_conflict_cnt + 16'd1;
      out_drop_cnt <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// Self-checking bench for cdb_arbiter: directed table, corner sequences and
// randomized traffic against a queue-level reference model.
module tb_cdb_arbiter;

  localparam int NS    = 4;
  localparam int DEPTH = 2;
  localparam int TW    = 5;
  localparam int VW    = 32;

  logic             clk;
  logic             rst;
  logic [NS-1:0]    in_src_valid;
  logic [NS*TW-1:0] in_src_tag;
  logic [NS*VW-1:0] in_src_val;
  logic [NS*4-1:0]  in_src_icc;
  logic [NS-1:0]    in_src_icc_wr;
  logic [NS-1:0]    out_src_ready;
  logic             out_CDB_broadcast;
  logic [TW-1:0]    out_CDB_tag;
  logic [VW-1:0]    out_CDB_val;
  logic [3:0]       out_ICC_flags;
  logic             out_ICC_wr;
  logic [2:0]       out_CDB_src;
`ifdef CDB_ARB_STATS_EN
  logic [15:0]      out_conflict_cnt;
  logic [7:0]       out_drop_cnt;
`endif

  cdb_arbiter #(.NUM_SRC(NS), .DEPTH(DEPTH), .TAG_W(TW), .VAL_W(VW)) dut (
    .clk               (clk),
    .rst               (rst),
    .in_src_valid      (in_src_valid),
    .in_src_tag        (in_src_tag),
    .in_src_val        (in_src_val),
    .in_src_icc        (in_src_icc),
    .in_src_icc_wr     (in_src_icc_wr),
    .out_src_ready     (out_src_ready),
    .out_CDB_broadcast (out_CDB_broadcast),
    .out_CDB_tag       (out_CDB_tag),
    .out_CDB_val       (out_CDB_val),
    .out_ICC_flags     (out_ICC_flags),
    .out_ICC_wr        (out_ICC_wr),
    .out_CDB_src       (out_CDB_src)
`ifdef CDB_ARB_STATS_EN
    ,
    .out_conflict_cnt  (out_conflict_cnt),
    .out_drop_cnt      (out_drop_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: plain arrays used as FIFOs plus a round-robin index.
  typedef struct packed {
    logic        iw;
    logic [3:0]  icc;
    logic [31:0] val;
    logic [4:0]  tag;
  } ent_t;

  ent_t        mbuf [NS][DEPTH];
  int          mcnt [NS];
  int          mp;
  logic        m_bc;
  logic [4:0]  m_tag;
  logic [31:0] m_val;
  logic [3:0]  m_icc;
  logic        m_iw;
  logic [2:0]  m_src;
  int          m_conf;
  int          m_drop;

  int vectors;
  int miscompares;

  task automatic model_reset();
    for (int k = 0; k < NS; k++) mcnt[k] = 0;
    mp = 0;
    m_bc = 1'b0; m_tag = 5'h1f; m_val = '0; m_icc = '0; m_iw = 1'b0; m_src = '0;
    m_conf = 0; m_drop = 0;
  endtask

  task automatic model_edge();
    int   g;
    int   nne;
    int   drops;
    int   k2;
    bit   acc [NS];
    ent_t e;
    if (rst) begin
      model_reset();
      return;
    end
    nne = 0;
    for (int k = 0; k < NS; k++) if (mcnt[k] > 0) nne++;
    g = -1;
    for (int i = 0; i < NS; i++) begin
      k2 = (mp + i) % NS;
      if (g < 0 && mcnt[k2] > 0) g = k2;
    end
    for (int k = 0; k < NS; k++) acc[k] = in_src_valid[k] && (mcnt[k] < DEPTH);
    if (g >= 0) begin
      e = mbuf[g][0];
      for (int j = 0; j < DEPTH-1; j++) mbuf[g][j] = mbuf[g][j+1];
      mcnt[g]--;
      m_bc = 1'b1; m_tag = e.tag; m_val = e.val; m_icc = e.icc; m_iw = e.iw;
      m_src = 3'(g);
      mp = (g + 1) % NS;
    end else begin
      m_bc = 1'b0;
      m_iw = 1'b0;
    end
    drops = 0;
    for (int k = 0; k < NS; k++) begin
      if (acc[k]) begin
        if (in_src_tag[k*TW +: TW] == 5'h1f) begin
          drops++;
        end else begin
          e.tag = in_src_tag[k*TW +: TW];
          e.val = in_src_val[k*VW +: VW];
          e.icc = in_src_icc[k*4 +: 4];
          e.iw  = in_src_icc_wr[k];
          mbuf[k][mcnt[k]] = e;
          mcnt[k]++;
        end
      end
    end
    if (nne >= 2 && m_conf < 65535) m_conf++;
    m_drop = (m_drop + drops > 255) ? 255 : m_drop + drops;
  endtask

  task automatic check(input string name);
    logic [NS-1:0] rdy;
    for (int k = 0; k < NS; k++) rdy[k] = (mcnt[k] < DEPTH);
    vectors++;
    if (out_CDB_broadcast !== m_bc || out_CDB_tag !== m_tag || out_CDB_val !== m_val ||
        out_ICC_flags !== m_icc || out_ICC_wr !== m_iw || out_CDB_src !== m_src ||
        out_src_ready !== rdy) begin
      miscompares++;
      $display("FAIL %s: got bc=%b tag=%0d val=%h icc=%h iw=%b src=%0d rdy=%b, want bc=%b tag=%0d val=%h icc=%h iw=%b src=%0d rdy=%b",
               name, out_CDB_broadcast, out_CDB_tag, out_CDB_val, out_ICC_flags, out_ICC_wr,
               out_CDB_src, out_src_ready, m_bc, m_tag, m_val, m_icc, m_iw, m_src, rdy);
    end
`ifdef CDB_ARB_STATS_EN
    vectors++;
    if (out_conflict_cnt !== 16'(m_conf) || out_drop_cnt !== 8'(m_drop)) begin
      miscompares++;
      $display("FAIL %s_stats: got conflict=%0d drop=%0d, want conflict=%0d drop=%0d",
               name, out_conflict_cnt, out_drop_cnt, m_conf, m_drop);
    end
`endif
  endtask

  task automatic expect_direct(input string name, input logic bc, input logic [4:0] tag,
                               input logic [2:0] src, input bit chk_data,
                               input logic [31:0] val, input logic iw);
    vectors++;
    if (out_CDB_broadcast !== bc || out_CDB_tag !== tag || out_CDB_src !== src ||
        (chk_data && (out_CDB_val !== val || out_ICC_wr !== iw))) begin
      miscompares++;
      $display("FAIL %s: got bc=%b tag=%0d src=%0d val=%h iw=%b, want bc=%b tag=%0d src=%0d val=%h iw=%b",
               name, out_CDB_broadcast, out_CDB_tag, out_CDB_src, out_CDB_val, out_ICC_wr,
               bc, tag, src, val, iw);
    end
  endtask

  task automatic cycle(input string name);
    @(posedge clk);
    model_edge();
    #1;
    check(name);
  endtask

  task automatic clear_in();
    in_src_valid = '0; in_src_tag = '0; in_src_val = '0; in_src_icc = '0; in_src_icc_wr = '0;
  endtask

  task automatic drive(input int k, input logic [4:0] tag, input logic [31:0] val,
                       input logic [3:0] icc, input logic iw);
    in_src_valid[k]          = 1'b1;
    in_src_tag[k*TW +: TW]   = tag;
    in_src_val[k*VW +: VW]   = val;
    in_src_icc[k*4 +: 4]     = icc;
    in_src_icc_wr[k]         = iw;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    check("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct packed {
    logic [3:0] vmask;
    logic [4:0] base;
    logic       bc;
    logic [4:0] tag;
    logic [2:0] src;
  } vec_t;

  vec_t tbl [9];

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int last2, maxgap, cnt2;
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    clear_in();
    model_reset();
    @(negedge clk);
    check("reset_init");
    @(negedge clk);
    rst = 1'b0;

    // Single push from src1: broadcast one cycle after the push, one cycle wide.
    drive(1, 5'b01000, 32'h0000_0006, 4'b0000, 1'b1);
    cycle("single_push");
    expect_direct("single_push_quiet", 1'b0, 5'h1f, 3'd0, 1'b0, '0, 1'b0);
    clear_in();
    cycle("single_bc");
    expect_direct("single_bc_direct", 1'b1, 5'b01000, 3'd1, 1'b1, 32'h6, 1'b1);
    cycle("single_after");
    expect_direct("single_after_direct", 1'b0, 5'b01000, 3'd1, 1'b1, 32'h6, 1'b0);

    // All four push together from p=0, then pointer wrap check via src3/src0.
    tbl[0] = '{4'b1111, 5'd0, 1'b0, 5'd31, 3'd0};
    tbl[1] = '{4'b0000, 5'd0, 1'b1, 5'd0,  3'd0};
    tbl[2] = '{4'b0000, 5'd0, 1'b1, 5'd1,  3'd1};
    tbl[3] = '{4'b0000, 5'd0, 1'b1, 5'd2,  3'd2};
    tbl[4] = '{4'b0000, 5'd0, 1'b1, 5'd3,  3'd3};
    tbl[5] = '{4'b0000, 5'd0, 1'b0, 5'd3,  3'd3};
    tbl[6] = '{4'b1001, 5'd8, 1'b0, 5'd3,  3'd3};
    tbl[7] = '{4'b0000, 5'd0, 1'b1, 5'd8,  3'd0};
    tbl[8] = '{4'b0000, 5'd0, 1'b1, 5'd11, 3'd3};
    reset_dut();
    for (int i = 0; i < 9; i++) begin
      clear_in();
      for (int k = 0; k < NS; k++)
        if (tbl[i].vmask[k]) drive(k, tbl[i].base + 5'(k), 32'h100 * (i + 1) + k, 4'(k), 1'(k));
      cycle("table");
      expect_direct($sformatf("table_row%0d", i), tbl[i].bc, tbl[i].tag, tbl[i].src, 1'b0, '0, 1'b0);
`ifdef CDB_ARB_STATS_EN
      if (i == 5) begin
        vectors++;
        if (out_conflict_cnt !== 16'd3) begin
          miscompares++;
          $display("FAIL conflict_three: got %0d want 3", out_conflict_cnt);
        end
      end
`endif
    end

    // src2 held valid while src0/src3 also stream: backpressure and fairness.
    reset_dut();
    last2 = -1; maxgap = 0; cnt2 = 0;
    for (int c = 0; c < 24; c++) begin
      clear_in();
      drive(0, 5'(c % 7),      {16'h0000, 8'(c), 8'h00}, 4'h1, 1'b1);
      drive(2, 5'(16 + c % 7), {16'h0002, 8'(c), 8'h00}, 4'h2, 1'b0);
      drive(3, 5'(24 + c % 7), {16'h0003, 8'(c), 8'h00}, 4'h3, 1'b1);
      cycle("hold");
      if (c == 1) begin
        vectors++;
        if (out_src_ready[2] !== 1'b0) begin
          miscompares++;
          $display("FAIL hold_ready_drop: got ready2=%b want 0", out_src_ready[2]);
        end
      end
      if (out_CDB_broadcast && out_CDB_src == 3'd2) begin
        if (last2 >= 0 && c - last2 > maxgap) maxgap = c - last2;
        last2 = c;
        cnt2++;
      end
    end
    vectors++;
    if (maxgap > NS || cnt2 < 4) begin
      miscompares++;
      $display("FAIL hold_fairness: got maxgap=%0d count=%0d, want maxgap<=%0d count>=4", maxgap, cnt2, NS);
    end

    // INVALID_TAG push is accepted but never broadcast.
    reset_dut();
    clear_in();
    drive(0, 5'h1f, 32'hDEAD_BEEF, 4'hF, 1'b1);
    #1;
    vectors++;
    if (out_src_ready[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL inv_ready: got %b want 1", out_src_ready[0]);
    end
    cycle("inv_push");
    clear_in();
    cycle("inv_idle1");
    expect_direct("inv_no_bc", 1'b0, 5'h1f, 3'd0, 1'b0, '0, 1'b0);
    cycle("inv_idle2");

    // Asynchronous reset between edges with three entries queued.
    reset_dut();
    clear_in();
    drive(0, 5'd1, 32'h11, 4'h1, 1'b1);
    drive(1, 5'd2, 32'h22, 4'h2, 1'b1);
    drive(2, 5'd3, 32'h33, 4'h3, 1'b1);
    cycle("q3_push");
    clear_in();
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check("async_rst");
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) cycle("post_rst_idle");

    // Randomized traffic, including occasional INVALID_TAG pushes.
    reset_dut();
    for (int c = 0; c < 400; c++) begin
      clear_in();
      for (int k = 0; k < NS; k++) begin
        if ($urandom_range(0, 99) < 60)
          drive(k, ($urandom_range(0, 15) == 0) ? 5'h1f : 5'($urandom_range(0, 30)),
                $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      end
      cycle("random");
    end
    clear_in();
    for (int c = 0; c < 6; c++) cycle("random_drain");

`ifdef CDB_ARB_STATS_EN
    // Two continuously busy sources drive the conflict counter into saturation.
    reset_dut();
    clear_in();
    drive(0, 5'd4, 32'hA0, 4'h0, 1'b0);
    drive(1, 5'd5, 32'hA1, 4'h0, 1'b0);
    for (int c = 0; c < 65545; c++) begin
      @(posedge clk);
      model_edge();
    end
    #1;
    check("conflict_sat");
    vectors++;
    if (out_conflict_cnt !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL conflict_saturate: got %h want ffff", out_conflict_cnt);
    end
    clear_in();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Receives result-broadcast requests from up to NUM_SRC functional units (ADD/MUL/DIV/LDST reservation stations) and drives the single shared Common Data Bus.
- Buffers each source's results in a small per-source FIFO and grants one entry per cycle by round-robin.
- Its registered CDB outputs feed every reservation station's CDB snoop inputs and the register status / ICC update logic.

Parameters:
- NUM_SRC, 4, number of requesting functional units (2..8).
- DEPTH, 2, entries per source FIFO (power of two, >=2).
- TAG_W, 5, tag width; all-ones (5'b11111) is INVALID_TAG.
- VAL_W, 32, result width.

Ports:
- clk  input  1  system clock, all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- in_src_valid  input  NUM_SRC  per-source result request.
- in_src_tag  input  NUM_SRC*TAG_W  packed tags; source k at [k*TAG_W +: TAG_W].
- in_src_val  input  NUM_SRC*VAL_W  packed result values.
- in_src_icc  input  NUM_SRC*4  packed {c,v,z,n} flags.
- in_src_icc_wr  input  NUM_SRC  entry updates ICC.
- out_src_ready  output  NUM_SRC  FIFO k can accept this cycle.
- out_CDB_broadcast  output  1  one-cycle pulse; bus data valid.
- out_CDB_tag  output  TAG_W  producing RS tag.
- out_CDB_val  output  VAL_W  result value.
- out_ICC_flags  output  4  {c,v,z,n} of the broadcast entry.
- out_ICC_wr  output  1  qualifies out_ICC_flags.
- out_CDB_src  output  3  index of the granted source.

Behaviour:
- Reset (async, rst=1):
  - FIFOs emptied; round-robin pointer = 0.
  - out_CDB_broadcast=0, out_CDB_tag=INVALID_TAG, out_CDB_val=0, out_ICC_flags=0, out_ICC_wr=0, out_CDB_src=0.
  - out_src_ready=all ones, asserted combinationally from the empty state.
  - Reset mid-operation discards all buffered results without broadcasting them.
- Enqueue:
  - Source k pushes on posedge clk when in_src_valid[k] && out_src_ready[k].
  - out_src_ready[k] = !full[k]. There is no push-while-full, even when k is popped the same cycle.
- Tag filter: a push whose tag == INVALID_TAG is accepted (ready honoured) but not stored and never broadcast.
- Arbitration, each cycle:
  - Candidates are the non-empty FIFOs.
  - Grant goes to the first non-empty FIFO searching from pointer p upward with wrap-around (p, p+1, ..., NUM_SRC-1, 0, ..., p-1).
  - On a grant to g, the head of FIFO g is popped and p becomes (g+1) mod NUM_SRC. With no grant, p holds.
- Output:
  - Registered. Pop in cycle N drives out_CDB_* at posedge N+1 (visible during cycle N+1).
  - out_CDB_broadcast is high exactly one cycle per granted entry.
  - Back-to-back broadcasts are allowed every cycle.
  - When idle, out_CDB_broadcast=0 and the data outputs hold their last values.
- Latency: a push into an empty FIFO with no competing entries is broadcast on the cycle after the push (push at edge N, pop decided during cycle N, broadcast after edge N+1).
- Ordering: per-source FIFO order is preserved. There is no ordering guarantee across sources.
- Simultaneous push and pop on the same FIFO in one cycle are legal when not full; the count is unchanged.
- Pointers wrap modulo DEPTH; full/empty are derived from an occupancy count (0..DEPTH).
- out_ICC_wr mirrors the stored in_src_icc_wr of the broadcast entry and is 0 when no broadcast occurs.
- Starvation bound: a non-empty FIFO is granted within NUM_SRC cycles.

Optional Feature:
- Macro: CDB_ARB_STATS_EN.
- Defined:
  - Adds output out_conflict_cnt, 16 bits, reset 0.
  - Increments by 1 each cycle in which two or more FIFOs are non-empty at arbitration; saturates at 16'hFFFF.
  - Adds output out_drop_cnt, 8 bits, saturating: counts accepted INVALID_TAG pushes.
- Undefined: neither port exists and there is no counter logic. All other behaviour is identical.

Test Plan:
- Reset, then a single push from src1 (tag 5'b01000, val 32'h0000_0006, icc_wr=1, icc 4'b0000) -> out_CDB_broadcast=1 for exactly one cycle, one cycle after the push, with tag 01000, val 6, out_CDB_src=1, out_ICC_wr=1.
- All 4 sources push in the same cycle, tags 0..3, with p=0 -> broadcasts in consecutive cycles with src order 0,1,2,3; p ends at 0.
- Hold src2 valid with the CDB fed by src0 and src3 continuously. DEPTH=2 -> src2 ready drops after 2 accepted pushes; src2 broadcasts at least once every 4 cycles; FIFO order is intact.
- Push with tag 5'b11111 from src0 -> ready=1, no broadcast, out_drop_cnt=1 (STATS build).
- Assert rst asynchronously between clock edges while 3 entries are queued -> outputs reach reset values immediately, no further broadcasts, all ready=1.
- STATS build: 3 cycles with two or more FIFOs non-empty -> out_conflict_cnt=3. Preload 16'hFFFE plus 3 further conflict cycles -> 16'hFFFF.
